// File: rtl/motor_pwm_scheduler_if.sv
// Command/status bundle between the SPI receive side and the PWM scheduler.
// The master drives the command word and strobe; the slave (scheduler) drives pins and status.
interface motor_pwm_scheduler_if #(
  parameter int NUM_CH = 4
);
  logic [31:0]       cmd_word;
  logic              cmd_strobe;
  logic [NUM_CH-1:0] pwm_out;
  logic              frame_start;
  logic              wdog_trip;
  logic [7:0]        cmd_count;
  logic [7:0]        err_count;

  modport master (
    output cmd_word, cmd_strobe,
    input  pwm_out, frame_start, wdog_trip, cmd_count, err_count
  );

  modport slave (
    input  cmd_word, cmd_strobe,
    output pwm_out, frame_start, wdog_trip, cmd_count, err_count
  );
endinterface

// File: rtl/motor_pwm_scheduler.sv
// Command scheduler and multi-channel PWM generator. Periods are staged in shadow
// registers and applied only at frame boundaries; a link watchdog zeroes all duty.
//
//   state     | meaning
//   ----------+----------------------------------------------
//   S_IDLE    | waiting for a synchronized strobe rising edge
//   S_CAPTURE | latch the command word
//   S_DECODE  | classify select, clamp period
//   S_COMMIT  | write shadow registers and counters
module motor_pwm_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int TICK_DIV    = 500,
  parameter int FRAME_TICKS = 2000,
  parameter int WDOG_FRAMES = 25
) (
  input logic                  clk,
  input logic                  rst_n,
  motor_pwm_scheduler_if.slave bus
);
  localparam int PW = 11;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = $clog2(WDOG_FRAMES + 1);
  localparam logic [PW-1:0] FRAME_MAX = PW'(FRAME_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DECODE, S_COMMIT} state_t;

  state_t r_state, w_state_next;
  logic   w_capture, w_decode, w_commit;

  logic r_stb_meta, r_stb_sync, r_stb_prev;
  logic w_edge;

  logic [7:0]        r_cmd_sel;
  logic [PW-1:0]     r_cmd_per;
  logic              w_sel_valid;
  logic [NUM_CH-1:0] w_sel_mask;
  logic [PW-1:0]     w_per_clamped;
  logic              r_dec_valid;
  logic [NUM_CH-1:0] r_dec_mask;
  logic [PW-1:0]     r_dec_period;
  logic              w_commit_ok, w_commit_bad;

  logic [TW-1:0] r_tick_cnt;
  logic [PW-1:0] r_frame_cnt, w_frame_cnt_next;
  logic          w_tick, w_boundary;

  logic [WW-1:0] r_wd_cnt;
  logic          w_trip_evt;
  logic          r_wdog_trip;

  logic [PW-1:0]     r_shadow      [NUM_CH];
  logic [PW-1:0]     r_active      [NUM_CH];
  logic [PW-1:0]     w_active_next [NUM_CH];
  logic [NUM_CH-1:0] r_pwm;
  logic              r_frame_start;
  logic [7:0]        r_cmd_count, r_err_count;

  // The strobe comes from the SPI clock domain; only the synchronized rising edge counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stb_meta <= 1'b0;
      r_stb_sync <= 1'b0;
      r_stb_prev <= 1'b0;
    end else begin
      r_stb_meta <= bus.cmd_strobe;
      r_stb_sync <= r_stb_meta;
      r_stb_prev <= r_stb_sync;
    end
  end

  assign w_edge = r_stb_sync & ~r_stb_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_decode     = 1'b0;
    w_commit     = 1'b0;
    unique case (r_state)
      S_IDLE:    if (w_edge) w_state_next = S_CAPTURE;
      S_CAPTURE: begin w_capture = 1'b1; w_state_next = S_DECODE; end
      S_DECODE:  begin w_decode  = 1'b1; w_state_next = S_COMMIT; end
      S_COMMIT:  begin w_commit  = 1'b1; w_state_next = S_IDLE;   end
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sel_mask    = '0;
    w_sel_valid   = (r_cmd_sel == 8'h00) || (r_cmd_sel == 8'hFF) ||
                    ((r_cmd_sel >= 8'd1) && (r_cmd_sel <= 8'(NUM_CH)));
    w_per_clamped = (r_cmd_per > FRAME_MAX) ? FRAME_MAX : r_cmd_per;
    for (int i = 0; i < NUM_CH; i++)
      w_sel_mask[i] = (r_cmd_sel == 8'hFF) || (r_cmd_sel == 8'(i + 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_sel    <= '0;
      r_cmd_per    <= '0;
      r_dec_valid  <= 1'b0;
      r_dec_mask   <= '0;
      r_dec_period <= '0;
    end else begin
      if (w_capture) begin
        r_cmd_sel <= bus.cmd_word[31:24];
        r_cmd_per <= bus.cmd_word[23:13];
      end
      if (w_decode) begin
        r_dec_valid  <= w_sel_valid;
        r_dec_mask   <= w_sel_mask;
        r_dec_period <= w_per_clamped;
      end
    end
  end

  assign w_commit_ok  = w_commit &  r_dec_valid;
  assign w_commit_bad = w_commit & ~r_dec_valid;

  assign w_tick     = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_boundary = w_tick && (r_frame_cnt == PW'(FRAME_TICKS - 1));

  always_comb begin
    w_frame_cnt_next = r_frame_cnt;
    if (w_boundary)  w_frame_cnt_next = '0;
    else if (w_tick) w_frame_cnt_next = r_frame_cnt + 1'b1;
  end

  // A valid commit landing on the tripping boundary keeps the link alive.
  assign w_trip_evt = w_boundary && !w_commit_ok && (r_wd_cnt == WW'(WDOG_FRAMES - 1));

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_active_next[i] = r_active[i];
      if (w_trip_evt)      w_active_next[i] = '0;
      else if (w_boundary) w_active_next[i] = r_shadow[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt    <= '0;
      r_frame_cnt   <= '0;
      r_frame_start <= 1'b0;
      r_wd_cnt      <= '0;
      r_wdog_trip   <= 1'b0;
      r_cmd_count   <= '0;
      r_err_count   <= '0;
    end else begin
      r_tick_cnt    <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_frame_cnt   <= w_frame_cnt_next;
      r_frame_start <= w_boundary;
      if (w_commit_ok) begin
        r_wd_cnt    <= '0;
        r_wdog_trip <= 1'b0;
        r_cmd_count <= r_cmd_count + 8'd1;
      end else begin
        if (w_boundary && (r_wd_cnt < WW'(WDOG_FRAMES))) r_wd_cnt <= r_wd_cnt + 1'b1;
        if (w_trip_evt) r_wdog_trip <= 1'b1;
      end
      if (w_commit_bad && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_active[i] <= w_active_next[i];
        r_pwm[i]    <= (w_frame_cnt_next < w_active_next[i]);
        if (w_trip_evt)                         r_shadow[i] <= '0;
        else if (w_commit_ok && r_dec_mask[i])  r_shadow[i] <= r_dec_period;
      end
    end
  end

  assign bus.pwm_out     = r_pwm;
  assign bus.frame_start = r_frame_start;
  assign bus.wdog_trip   = r_wdog_trip;
  assign bus.cmd_count   = r_cmd_count;
  assign bus.err_count   = r_err_count;
endmodule

// File: tb/tb_motor_pwm_scheduler.sv
// Randomized bench for motor_pwm_scheduler: a frame-level reference model predicts per-frame
// high times and status; a monitor measures each finished frame at frame_start and compares.
module tb_motor_pwm_scheduler;
  localparam int NCH = 4;
  localparam int TD  = 4;
  localparam int FT  = 20;
  localparam int WF  = 3;
  localparam int FD  = FT * TD;
  localparam int NFR = 40;

  typedef struct {
    int unsigned hi [NCH];
    bit          trip;
    int unsigned cmd;
    int unsigned err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  motor_pwm_scheduler_if #(.NUM_CH(NCH)) bus ();

  motor_pwm_scheduler #(
    .NUM_CH(NCH), .TICK_DIV(TD), .FRAME_TICKS(FT), .WDOG_FRAMES(WF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int f_cyc = 0;
  bit mon_en = 1'b0;
  exp_t sb_q[$];

  int m_shadow [NCH];
  int m_active [NCH];
  int m_wd, m_cmd, m_err;
  bit m_trip;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic end_bench();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Monitor: counts high cycles per channel; each frame_start closes the previous frame.
  initial begin : monitor
    int unsigned cnt [NCH];
    exp_t e;
    foreach (cnt[i]) cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        foreach (cnt[i]) cnt[i] = 0;
      end else if (mon_en) begin
        if (bus.frame_start) begin
          if (sb_q.size() == 0) begin
            chk("sb_empty", 0, 1);
          end else begin
            e = sb_q.pop_front();
            for (int i = 0; i < NCH; i++)
              chk($sformatf("hi_time_ch%0d", i), int'(cnt[i]), int'(e.hi[i]));
            chk("wdog_trip", int'(bus.wdog_trip), int'(e.trip));
            chk("cmd_count", int'(bus.cmd_count), int'(e.cmd));
            chk("err_count", int'(bus.err_count), int'(e.err));
          end
          for (int i = 0; i < NCH; i++) cnt[i] = bus.pwm_out[i] ? 1 : 0;
        end else begin
          for (int i = 0; i < NCH; i++) cnt[i] += bus.pwm_out[i] ? 1 : 0;
        end
      end
    end
  end

  function automatic bit sel_ok(input logic [7:0] s);
    return (s == 8'h00) || (s == 8'hFF) || (int'(s) >= 1 && int'(s) <= NCH);
  endfunction

  function automatic int clampp(input int p);
    return (p > FT) ? FT : p;
  endfunction

  task automatic model_cmd(input logic [7:0] s, input int p);
    if (sel_ok(s)) begin
      m_cmd  = (m_cmd + 1) % 256;
      m_wd   = 0;
      m_trip = 1'b0;
      if (s == 8'hFF) foreach (m_shadow[i]) m_shadow[i] = clampp(p);
      else if (s != 8'h00) m_shadow[int'(s) - 1] = clampp(p);
    end else if (m_err < 255) begin
      m_err++;
    end
  endtask

  task automatic model_boundary();
    if (m_wd < WF) begin
      m_wd++;
      if (m_wd == WF) begin
        m_trip = 1'b1;
        foreach (m_shadow[i]) begin m_shadow[i] = 0; m_active[i] = 0; end
        return;
      end
    end
    foreach (m_active[i]) m_active[i] = m_shadow[i];
  endtask

  task automatic model_reset();
    foreach (m_shadow[i]) begin m_shadow[i] = 0; m_active[i] = 0; end
    m_wd = 0; m_cmd = 0; m_err = 0; m_trip = 1'b0;
  endtask

  task automatic issue_cmd(input logic [7:0] s, input int p);
    bus.cmd_word   = {s, 11'(p), 13'($urandom)};
    bus.cmd_strobe = 1'b1;
    repeat (3) @(negedge clk);
    bus.cmd_strobe = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Strobe timed so that COMMIT lands exactly on the next boundary cycle.
  task automatic issue_collide(input logic [7:0] s, input int p);
    while (cyc < f_cyc + FD - 6) @(negedge clk);
    bus.cmd_word   = {s, 11'(p), 13'($urandom)};
    bus.cmd_strobe = 1'b1;
    repeat (3) @(negedge clk);
    bus.cmd_strobe = 1'b0;
    repeat (3) @(negedge clk);
    chk("collide_align", int'(bus.frame_start), 1);
    f_cyc = cyc;
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 2 * FD && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_start) seen = 1'b1;
    end
    if (!seen) begin
      chk("frame_timeout", 0, 1);
      end_bench();
    end
    f_cyc = cyc;
  endtask

  function automatic logic [7:0] rand_sel();
    case ($urandom_range(0, 9))
      0:       return 8'h00;
      1, 2:    return 8'hFF;
      3:       return 8'($urandom_range(NCH + 1, 254));
      default: return 8'($urandom_range(1, NCH));
    endcase
  endfunction

  function automatic int rand_per();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, FT));
  endfunction

  logic [7:0] st_s [3];
  int         st_p [3];
  logic [7:0] st_cs;
  int         st_cp;
  int         st_n;
  bit         st_col;
  exp_t       st_e;
  int         st_got;

  initial begin : stimulus
    bus.cmd_word   = '0;
    bus.cmd_strobe = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    chk("rst_pwm", int'(bus.pwm_out), 0);
    chk("rst_frame_start", int'(bus.frame_start), 0);
    chk("rst_wdog", int'(bus.wdog_trip), 0);
    chk("rst_cmd_count", int'(bus.cmd_count), 0);
    chk("rst_err_count", int'(bus.err_count), 0);
    rst_n  = 1'b1;
    f_cyc  = cyc;
    mon_en = 1'b1;

    for (int fr = 0; fr < NFR; fr++) begin
      st_n = 0; st_col = 1'b0; st_cs = 8'h00; st_cp = 0;
      case (fr)
        0: begin st_n = 1; st_s[0] = 8'h01; st_p[0] = 15;   end
        1: begin st_n = 1; st_s[0] = 8'hFF; st_p[0] = 2047; end
        2: begin st_n = 1; st_s[0] = 8'h07; st_p[0] = 5;    end
        3: begin st_n = 1; st_s[0] = 8'h03; st_p[0] = 10;   end
        4, 5, 6: st_n = 0;
        7: begin st_n = 1; st_s[0] = 8'h00; st_p[0] = 0;    end
        8: begin st_col = 1'b1; st_cs = 8'h01; st_cp = 12;  end
        default: begin
          st_n = int'($urandom_range(0, 3));
          if (st_n == 3) st_n = 0;
          for (int k = 0; k < st_n; k++) begin st_s[k] = rand_sel(); st_p[k] = rand_per(); end
          st_col = ($urandom_range(0, 4) == 0);
          if (st_col) begin st_cs = rand_sel(); st_cp = rand_per(); end
        end
      endcase

      for (int k = 0; k < st_n; k++) begin
        issue_cmd(st_s[k], st_p[k]);
        model_cmd(st_s[k], st_p[k]);
      end

      for (int i = 0; i < NCH; i++) st_e.hi[i] = m_active[i] * TD;
      if (st_col && sel_ok(st_cs)) begin
        foreach (m_active[i]) m_active[i] = m_shadow[i];
        model_cmd(st_cs, st_cp);
      end else begin
        model_boundary();
        if (st_col) model_cmd(st_cs, st_cp);
      end
      st_e.trip = m_trip;
      st_e.cmd  = m_cmd;
      st_e.err  = m_err;
      sb_q.push_back(st_e);

      if (st_col) issue_collide(st_cs, st_cp);
      else        wait_frame();
    end
    @(negedge clk);
    mon_en = 1'b0;
    chk("sb_drained", sb_q.size(), 0);

    // Asynchronous reset in the middle of a high pulse.
    issue_cmd(8'h01, 15);
    wait_frame();
    wait_frame();
    repeat (2) @(negedge clk);
    chk("mid_pulse_high", int'(bus.pwm_out[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", int'(bus.pwm_out), 0);
    chk("async_rst_cmd", int'(bus.cmd_count), 0);
    chk("async_rst_err", int'(bus.err_count), 0);
    chk("async_rst_wdog", int'(bus.wdog_trip), 0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    st_got = -1;
    for (int i = 1; i <= 2 * FD && st_got < 0; i++) begin
      @(negedge clk);
      if (bus.frame_start) st_got = i;
    end
    chk("first_frame_after_rst", st_got, FD);

    // Counter wrap and saturation.
    for (int k = 0; k < 259; k++) issue_cmd(8'h00, 0);
    chk("cmd_count_wrap", int'(bus.cmd_count), 3);
    for (int k = 0; k < 257; k++) issue_cmd(8'h80, 7);
    chk("err_count_sat", int'(bus.err_count), 255);
    chk("cmd_count_hold", int'(bus.cmd_count), 3);
    chk("pwm_idle", int'(bus.pwm_out), 0);

    end_bench();
  end
endmodule
